pong_match_ctrl: RTL
====================

Name: pong_match_ctrl

Overview:
- Game-flow controller for the Pong design.
- Sequences a match through title, serve countdown, live play, point pause and game-over.
- Owns both player scores and gates the ball/paddle datapath in pixel_gen via play_en and ball_rst.
- Drives the title/game-over text selection and feeds score1/score2 to pong_text and the seven-segment scanner.

Parameters:
- WIN_SCORE, 9, score that ends the match; legal range 1..15.
- SERVE_FRAMES, 120, frame ticks spent in SERVE before the ball is released; must be at least 1.
- POINT_FRAMES, 60, frame ticks of freeze after a point; must be at least 1.
- OVER_FRAMES, 180, frame ticks in OVER before a button may restart; must be at least 1.
- FCW, 9, frame-counter width; must satisfy 2^FCW > max(SERVE_FRAMES, POINT_FRAMES, OVER_FRAMES).

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame (start of vertical blank).
- up  in  1  debounced button level, player 1.
- down  in  1  debounced button level, player 1.
- up1  in  1  debounced button level, player 2.
- down1  in  1  debounced button level, player 2.
- miss_left  in  1  one-cycle pulse: ball passed the left wall; player 2 scores.
- miss_right  in  1  one-cycle pulse: ball passed the right wall; player 1 scores.
- state  out  3  TITLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
- title_on  out  1  high in TITLE.
- play_en  out  1  high in PLAY; enables ball and paddle motion.
- ball_rst  out  1  high in TITLE and SERVE; holds the ball at centre.
- serve_dir  out  1  initial ball x direction: 0 = left, 1 = right.
- frames_left  out  FCW  current frame-counter value, used for the countdown display.
- score1  out  4  player 1 score.
- score2  out  4  player 2 score.
- game_over  out  1  high in OVER.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk_100MHz. All outputs are registered.
- Reset values: state=TITLE, title_on=1, ball_rst=1, play_en=0, game_over=0, serve_dir=0, frames_left=0, score1=0, score2=0.
- Button edge detector:
  - any = up|down|up1|down1; btn_prev is registered.
  - btn_prev resets to 1, so a button held through reset does not trigger anything.
  - press = any & ~btn_prev.
- Frame counter: loaded with N on entry to a timed state. On each frame_tick, if the counter is 1 the exit transition fires; otherwise the counter decrements. Latency: the new state is visible on the cycle after the triggering tick.
- TITLE:
  - Scores are held at 0.
  - press -> SERVE, counter=SERVE_FRAMES, serve_dir=0.
- SERVE: counter expires -> PLAY.
- PLAY, scoring:
  - miss_left alone -> score2+1, serve_dir<=0 (serve toward player 1).
  - miss_right alone -> score1+1, serve_dir<=1.
  - Both in the same cycle -> neither score changes, serve_dir is unchanged, go to POINT.
  - After a score, if the new value equals WIN_SCORE -> OVER with counter=OVER_FRAMES; otherwise -> POINT with counter=POINT_FRAMES.
- POINT:
  - play_en=0 and ball_rst=0, so the ball freezes in place.
  - Counter expires -> SERVE, counter=SERVE_FRAMES.
- OVER:
  - Scores are frozen.
  - Counter decrements to 0 and holds there; frame_tick in this state never wraps the counter.
  - press is ignored while counter>0.
  - press with counter=0 -> TITLE; scores clear to 0 in the same cycle.
- Ignored inputs:
  - miss_left/miss_right outside PLAY.
  - press outside TITLE and OVER.
  - frame_tick in TITLE and PLAY.
- Simultaneous events:
  - A miss and a frame_tick in the same PLAY cycle: the miss wins.
  - A press and a frame_tick in the same OVER cycle with counter=1: the counter goes to 0 and the press is ignored.
- Scores never exceed WIN_SCORE; there is no 4-bit wrap.
- Undefined state encodings (5..7) -> TITLE on the next clock.
- Reset mid-operation: all registers return to reset values on the asynchronous assert, with no partial score update.

Test Plan (bench parameters: WIN_SCORE=3, SERVE_FRAMES=3, POINT_FRAMES=2, OVER_FRAMES=2):
- Hold up through reset, then release, then press down -> no exit from TITLE until the down rising edge; then state=1 and frames_left=3.
- In SERVE, apply 3 frame_ticks -> state=2 one cycle after the third tick; play_en=1 and ball_rst=0.
- In PLAY, pulse miss_right -> score1=1, serve_dir=1, state=3; after 2 ticks state=1 with frames_left=3.
- In PLAY, pulse miss_left and miss_right in the same cycle -> scores unchanged, state=3, serve_dir unchanged.
- Drive score2 to 3 via miss_left -> state=4, game_over=1:
  - A press before 2 ticks -> no change.
  - A press after 2 ticks -> state=0 and both scores 0.
- Assert reset mid-PLAY with score1=2 -> state=0, scores 0, title_on=1 immediately and asynchronously; miss pulses during TITLE leave scores 0.

Source files
------------

// File: rtl/pong_match_ctrl_if.sv
// Game-flow signal bundle between the Pong datapath/inputs and the match controller.
// The slave side is the controller; the master side drives frame, button and miss events.
interface pong_match_ctrl_if #(
   parameter int FCW = 9
);
   logic           frame_tick;
   logic           up;
   logic           down;
   logic           up1;
   logic           down1;
   logic           miss_left;
   logic           miss_right;
   logic [2:0]     state;
   logic           title_on;
   logic           play_en;
   logic           ball_rst;
   logic           serve_dir;
   logic [FCW-1:0] frames_left;
   logic [3:0]     score1;
   logic [3:0]     score2;
   logic           game_over;

   modport slave (
      input  frame_tick, up, down, up1, down1, miss_left, miss_right,
      output state, title_on, play_en, ball_rst, serve_dir, frames_left,
             score1, score2, game_over
   );

   modport master (
      output frame_tick, up, down, up1, down1, miss_left, miss_right,
      input  state, title_on, play_en, ball_rst, serve_dir, frames_left,
             score1, score2, game_over
   );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match controller: title -> serve countdown -> play -> point pause -> game over.
// Owns both scores, the serve direction and a shared frame counter; all outputs registered.
module pong_match_ctrl #(
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_FRAMES = 120,
   parameter int POINT_FRAMES = 60,
   parameter int OVER_FRAMES  = 180,
   parameter int FCW          = 9
) (
   input  logic                 clk_100MHz,
   input  logic                 reset,
   pong_match_ctrl_if.slave     bus
);

   typedef enum logic [2:0] {
      ST_TITLE = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_POINT = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam logic [FCW-1:0] SERVE_N = FCW'(SERVE_FRAMES);
   localparam logic [FCW-1:0] POINT_N = FCW'(POINT_FRAMES);
   localparam logic [FCW-1:0] OVER_N  = FCW'(OVER_FRAMES);
   localparam logic [FCW-1:0] CNT_ONE = FCW'(1);
   localparam logic [FCW-1:0] CNT_ZER = '0;
   localparam logic [3:0]     WIN_N   = 4'(WIN_SCORE);

   state_t         state_r,     state_nxt_s;
   logic [FCW-1:0] cnt_r,       cnt_nxt_s;
   logic [3:0]     score1_r,    score1_nxt_s;
   logic [3:0]     score2_r,    score2_nxt_s;
   logic           serve_dir_r, serve_dir_nxt_s;
   logic           btn_prev_r;
   logic           title_on_r;
   logic           play_en_r;
   logic           ball_rst_r;
   logic           game_over_r;

   logic           any_s;
   logic           press_s;
   logic           expire_s;
   logic [3:0]     score1_inc_s;
   logic [3:0]     score2_inc_s;

   assign any_s        = bus.up | bus.down | bus.up1 | bus.down1;
   assign press_s      = any_s & ~btn_prev_r;
   // A tick on a count of 1 (or a stray 0) ends the timed state instead of decrementing.
   assign expire_s     = bus.frame_tick & (cnt_r <= CNT_ONE);
   assign score1_inc_s = score1_r + 4'd1;
   assign score2_inc_s = score2_r + 4'd1;

   // Next-state, counter, score and serve-direction decisions for the match flow.
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      score1_nxt_s    = score1_r;
      score2_nxt_s    = score2_r;
      serve_dir_nxt_s = serve_dir_r;
      case (state_r)
         ST_TITLE: begin
            score1_nxt_s = 4'd0;
            score2_nxt_s = 4'd0;
            if (press_s) begin
               state_nxt_s     = ST_SERVE;
               cnt_nxt_s       = SERVE_N;
               serve_dir_nxt_s = 1'b0;
            end else begin
               state_nxt_s = ST_TITLE;
            end
         end
         ST_SERVE: begin
            if (expire_s) begin
               state_nxt_s = ST_PLAY;
            end else if (bus.frame_tick) begin
               cnt_nxt_s = cnt_r - CNT_ONE;
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         ST_PLAY: begin
            // Misses take priority over frame ticks, which are ignored here anyway.
            if (bus.miss_left && bus.miss_right) begin
               state_nxt_s = ST_POINT;
               cnt_nxt_s   = POINT_N;
            end else if (bus.miss_left) begin
               score2_nxt_s    = score2_inc_s;
               serve_dir_nxt_s = 1'b0;
               if (score2_inc_s == WIN_N) begin
                  state_nxt_s = ST_OVER;
                  cnt_nxt_s   = OVER_N;
               end else begin
                  state_nxt_s = ST_POINT;
                  cnt_nxt_s   = POINT_N;
               end
            end else if (bus.miss_right) begin
               score1_nxt_s    = score1_inc_s;
               serve_dir_nxt_s = 1'b1;
               if (score1_inc_s == WIN_N) begin
                  state_nxt_s = ST_OVER;
                  cnt_nxt_s   = OVER_N;
               end else begin
                  state_nxt_s = ST_POINT;
                  cnt_nxt_s   = POINT_N;
               end
            end else begin
               state_nxt_s = ST_PLAY;
            end
         end
         ST_POINT: begin
            if (expire_s) begin
               state_nxt_s = ST_SERVE;
               cnt_nxt_s   = SERVE_N;
            end else if (bus.frame_tick) begin
               cnt_nxt_s = cnt_r - CNT_ONE;
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         ST_OVER: begin
            // Counter parks at zero; only then does a press restart the match.
            if (cnt_r == CNT_ZER) begin
               if (press_s) begin
                  state_nxt_s  = ST_TITLE;
                  score1_nxt_s = 4'd0;
                  score2_nxt_s = 4'd0;
               end else begin
                  state_nxt_s = ST_OVER;
               end
            end else if (bus.frame_tick) begin
               cnt_nxt_s = cnt_r - CNT_ONE;
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         default: begin
            state_nxt_s  = ST_TITLE;
            cnt_nxt_s    = CNT_ZER;
            score1_nxt_s = 4'd0;
            score2_nxt_s = 4'd0;
         end
      endcase
   end

   // State, counter, scores, button history and registered decoded outputs.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_r     <= ST_TITLE;
         cnt_r       <= CNT_ZER;
         score1_r    <= 4'd0;
         score2_r    <= 4'd0;
         serve_dir_r <= 1'b0;
         btn_prev_r  <= 1'b1;
         title_on_r  <= 1'b1;
         play_en_r   <= 1'b0;
         ball_rst_r  <= 1'b1;
         game_over_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         score1_r    <= score1_nxt_s;
         score2_r    <= score2_nxt_s;
         serve_dir_r <= serve_dir_nxt_s;
         btn_prev_r  <= any_s;
         title_on_r  <= (state_nxt_s == ST_TITLE);
         play_en_r   <= (state_nxt_s == ST_PLAY);
         ball_rst_r  <= (state_nxt_s == ST_TITLE) || (state_nxt_s == ST_SERVE);
         game_over_r <= (state_nxt_s == ST_OVER);
      end
   end

   assign bus.state       = state_r;
   assign bus.frames_left = cnt_r;
   assign bus.score1      = score1_r;
   assign bus.score2      = score2_r;
   assign bus.serve_dir   = serve_dir_r;
   assign bus.title_on    = title_on_r;
   assign bus.play_en     = play_en_r;
   assign bus.ball_rst    = ball_rst_r;
   assign bus.game_over   = game_over_r;

endmodule
